// File: rtl/debug_disp_pkg.sv
// Shared types, sizes and the hex-to-7-segment decoder for the debug display.
package debug_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CAP
    } ddc_state_t;

    localparam int unsigned DISP_DEPTH  = 32;
    localparam int unsigned DISP_DIGITS = 8;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned IDX_W       = $clog2(DISP_DEPTH);
    localparam int unsigned PTR_W       = $clog2(DISP_DIGITS);

    // Active-low cathodes ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/debug_display_ctrl_seg7_mux.sv
// Eight-digit multiplexed 7-segment driver showing a 32-bit word as hex.
// Ports: clk, rst (sync, active-high), word (value shown),
//        seg_an (active-low one-hot anodes), seg_cat (active-low cathodes {g..a}).
module seg7_mux
    import debug_disp_pkg::*;
#(
    parameter int unsigned DIGIT_DIV = 10_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_W-1:0]      word,
    output logic [DISP_DIGITS-1:0] seg_an,
    output logic [6:0]             seg_cat
);

    localparam int unsigned DCNT_W = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;

    logic [DCNT_W-1:0] dcnt;
    logic [PTR_W-1:0]  ptr;
    logic              dwrap;

    assign dwrap = (dcnt == DCNT_W'(DIGIT_DIV - 1));

    // Digit timer, pointer rotation and registered anode/cathode drive (digit 0 = LSB nibble).
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt    <= '0;
            ptr     <= '0;
            seg_an  <= ~DISP_DIGITS'(1);
            seg_cat <= hex7seg(4'h0);
        end else begin
            dcnt    <= dwrap ? '0 : dcnt + DCNT_W'(1);
            if (dwrap) begin
                ptr <= ptr + PTR_W'(1);
            end
            seg_an  <= ~(DISP_DIGITS'(1) << ptr);
            seg_cat <= hex7seg(word[{ptr, 2'b00} +: 4]);
        end
    end

endmodule

// File: rtl/debug_display_ctrl.sv
// Arbitrates the debug-display FIFO between MMIO writes and a periodic refresh read,
// and shows the fetched entry as hex on an 8-digit 7-segment display.
// Ports: clk, Rst (sync, active-high); wr_valid/wr_ready/wr_data (MMIO write);
//        sel_entry/auto_scan (entry selection); fifo_wea/fifo_din/fifo_addr/fifo_dout (FIFO);
//        shown_word/shown_idx (displayed entry); seg_an/seg_cat (display pins).
module debug_display_ctrl
    import debug_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned DIGIT_DIV   = 10_000,
    parameter int unsigned SCAN_DWELL  = 200,
    parameter int unsigned STARVE_MAX  = 8
) (
    input  logic                   clk,
    input  logic                   Rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic [IDX_W-1:0]       sel_entry,
    input  logic                   auto_scan,
    output logic                   fifo_wea,
    output logic [WORD_W-1:0]      fifo_din,
    output logic [IDX_W-1:0]       fifo_addr,
    input  logic [WORD_W-1:0]      fifo_dout,
    output logic [WORD_W-1:0]      shown_word,
    output logic [IDX_W-1:0]       shown_idx,
    output logic [DISP_DIGITS-1:0] seg_an,
    output logic [6:0]             seg_cat
);

    localparam int unsigned RFSH_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DWELL_W  = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    ddc_state_t          state_q, state_d;
    logic [RFSH_W-1:0]   rfsh_cnt_q;
    logic                rfsh_pend_q;
    logic                rfsh_wrap;
    logic [DWELL_W-1:0]  dwell_q;
    logic [IDX_W-1:0]    scan_idx_q;
    logic [STARVE_W-1:0] starve_q;
    logic [WORD_W-1:0]   din_q;

    assign rfsh_wrap = (rfsh_cnt_q == RFSH_W'(REFRESH_DIV - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and write-side strobes; a pending refresh only pre-empts a
    // waiting write once writes have been granted STARVE_MAX times in a row.
    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        fifo_wea = 1'b0;
        fifo_din = din_q;
        case (state_q)
            IDLE: begin
                if (rfsh_pend_q && (!wr_valid || starve_q == STARVE_W'(STARVE_MAX))) begin
                    state_d = RD_ADDR;
                end else if (wr_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                fifo_wea = 1'b1;
                fifo_din = wr_data;
                state_d  = IDLE;
            end
            RD_ADDR: state_d = RD_CAP;
            RD_CAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Refresh timer, scan stepping, starvation tracking and captured display data.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rfsh_cnt_q  <= '0;
            rfsh_pend_q <= 1'b0;
            dwell_q     <= '0;
            scan_idx_q  <= '0;
            starve_q    <= '0;
            din_q       <= '0;
            fifo_addr   <= '0;
            shown_word  <= '0;
            shown_idx   <= '0;
        end else begin
            rfsh_cnt_q <= rfsh_wrap ? '0 : rfsh_cnt_q + RFSH_W'(1);

            // A new wrap outranks the clear so a request landing on RD_CAP is kept.
            if (rfsh_wrap) begin
                rfsh_pend_q <= 1'b1;
            end else if (state_q == RD_CAP) begin
                rfsh_pend_q <= 1'b0;
            end

            if (rfsh_wrap && auto_scan) begin
                if (dwell_q == DWELL_W'(SCAN_DWELL - 1)) begin
                    dwell_q    <= '0;
                    scan_idx_q <= scan_idx_q + IDX_W'(1);
                end else begin
                    dwell_q <= dwell_q + DWELL_W'(1);
                end
            end

            if (state_q == WRITE && rfsh_pend_q && starve_q != STARVE_W'(STARVE_MAX)) begin
                starve_q <= starve_q + STARVE_W'(1);
            end else if (state_q == RD_CAP) begin
                starve_q <= '0;
            end

            if (state_q == WRITE) begin
                din_q <= wr_data;
            end

            // Target entry is latched as the read starts so selection changes wait for the next read.
            if (state_q == IDLE && state_d == RD_ADDR) begin
                fifo_addr <= auto_scan ? scan_idx_q : sel_entry;
            end

            if (state_q == RD_CAP) begin
                shown_word <= fifo_dout;
                shown_idx  <= fifo_addr;
            end
        end
    end

    seg7_mux #(
        .DIGIT_DIV (DIGIT_DIV)
    ) u_seg7_mux (
        .clk     (clk),
        .rst     (Rst),
        .word    (shown_word),
        .seg_an  (seg_an),
        .seg_cat (seg_cat)
    );

endmodule
